// File: rtl/pwm_pkg.sv
// Shared PWM link constants and capture FSM state type.
// Used by the PWM generator and pwm_duty_capture.
package pwm_pkg;

  localparam int PWM_DUTY_W = 8;
  localparam int PWM_PERIOD = 2 ** PWM_DUTY_W;

  typedef enum logic [2:0] {
    ARM,
    WAIT_RISE,
    HIGH,
    LOW,
    STATIC
  } cap_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with history flop and edge strobes.
// Ports: clk, rst (async high), din (async in), level, rise, fall.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/pwm_duty_capture.sv
// Recovers the duty value of a 2**DUTY_W-clock PWM frame.
// Ports: Clock_in, Reset, Pwm_in -> Duty_cycle, Valid, Period_err, Static_level.
module pwm_duty_capture
  import pwm_pkg::*;
#(
  parameter int DUTY_W  = PWM_DUTY_W,
  parameter int TIMEOUT = 512
) (
  input  logic              Clock_in,
  input  logic              Reset,
  input  logic              Pwm_in,
  output logic [DUTY_W-1:0] Duty_cycle,
  output logic              Valid,
  output logic              Period_err,
  output logic              Static_level
);

  localparam int PERIOD = 2 ** DUTY_W;
  localparam int CW     = $clog2(TIMEOUT + 1);
  localparam int SW     = DUTY_W + 2;

  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT);
  localparam logic [SW-1:0] P_SUM = SW'(PERIOD);

  logic            level, rise, fall;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   high_len;
  logic [SW-1:0]   period_sum;
  logic            timeout;
  cap_state_t      state;

  sync_edge_detect u_sync (
    .clk   (Clock_in),
    .rst   (Reset),
    .din   (Pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // Phase length: an edge restarts at 1 so a phase of N clocks
  // reads N on the edge that closes it.
  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (rise | fall) begin
      cnt <= CW'(1);
    end else if (cnt != T_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign period_sum = SW'(high_len) + SW'(cnt);

  // Edges win over timeout; STATIC never re-times out.
  assign timeout = (cnt == T_MAX) && !(rise || fall)
                && (state != STATIC);

  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      state        <= ARM;
      high_len     <= '0;
      Duty_cycle   <= '0;
      Valid        <= 1'b0;
      Period_err   <= 1'b0;
      Static_level <= 1'b0;
    end else begin
      Valid      <= 1'b0;
      Period_err <= 1'b0;
      if (timeout) begin
        state        <= STATIC;
        Duty_cycle   <= level ? '1 : '0;
        Valid        <= 1'b1;
        Static_level <= level;
      end else begin
        unique case (state)
          ARM: begin
            if (fall) state <= WAIT_RISE;
          end
          WAIT_RISE: begin
            if (rise) state <= HIGH;
          end
          HIGH: begin
            if (fall) begin
              high_len <= cnt;
              state    <= LOW;
            end
          end
          LOW: begin
            if (rise) begin
              if (period_sum == P_SUM) begin
                Duty_cycle <= high_len[DUTY_W-1:0];
                Valid      <= 1'b1;
              end else begin
                Period_err <= 1'b1;
              end
              state <= HIGH;
            end
          end
          STATIC: begin
            if (rise) begin
              state        <= HIGH;
              Static_level <= 1'b0;
            end else if (fall) begin
              state        <= WAIT_RISE;
              Static_level <= 1'b0;
            end
          end
          default: state <= ARM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Directed bench for pwm_duty_capture.
// A simple on-clock PWM source drives the line.
module tb_pwm_duty_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm = 1'b0;
  logic [7:0] duty;
  logic       vld;
  logic       perr_o;
  logic       stat;

  always #5 clk = ~clk;

  pwm_duty_capture #(
    .DUTY_W  (8),
    .TIMEOUT (512)
  ) dut (
    .Clock_in     (clk),
    .Reset        (rst),
    .Pwm_in       (pwm),
    .Duty_cycle   (duty),
    .Valid        (vld),
    .Period_err   (perr_o),
    .Static_level (stat)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rel = 0;
  int vq[$];
  int tq[$];
  int perr_n = 0;
  int both_n = 0;

  // Source: high for g_hi of g_len clocks; pending n_* load at wrap.
  int g_ctr = 0;
  int g_hi = 0;
  int g_len = 256;
  int n_hi = 0;
  int n_len = 256;

  always @(posedge clk) cyc++;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (g_ctr + 1 >= g_len) begin
        g_ctr = 0;
        g_hi  = n_hi;
        g_len = n_len;
      end else begin
        g_ctr++;
      end
      pwm = (g_ctr < g_hi);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (vld) begin
        vq.push_back(int'(duty));
        tq.push_back(cyc);
      end
      if (perr_o) perr_n++;
      if (vld && perr_o) both_n++;
    end
  end

  task automatic check(input string tag, input int got,
                       input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic clr();
    vq.delete();
    tq.delete();
    perr_n = 0;
  endtask

  task automatic set_now(input int hi, input int len);
    g_hi  = hi;
    n_hi  = hi;
    g_len = len;
    n_len = len;
    g_ctr = 0;
    pwm   = (hi > 0);
  endtask

  task automatic do_reset(input bit chk);
    wait_clk(1);
    rst = 1'b1;
    wait_clk(3);
    if (chk) begin
      check("rst_duty", duty, 0);
      check("rst_valid", vld, 0);
      check("rst_perr", perr_o, 0);
      check("rst_static", stat, 0);
    end
    rst = 1'b0;
    rel = cyc;
    clr();
  endtask

  task automatic wait_vals(input int n, input int budget,
                           input string tag);
    int k = 0;
    while (vq.size() < n && k < budget) begin
      wait_clk(1);
      k++;
    end
    check(tag, int'(vq.size() >= n), 1);
  endtask

  initial begin
    int sw[2];
    int k;
    sw[0] = 1;
    sw[1] = 255;

    // Reset values and constant-low line
    set_now(0, 256);
    do_reset(1'b1);
    wait_vals(1, 700, "d0_seen");
    check("d0_duty", vq[0], 0);
    check("d0_when", int'(tq[0] - rel >= 510 && tq[0] - rel <= 516), 1);
    wait_clk(600);
    check("d0_once", vq.size(), 1);
    check("d0_static", stat, 0);

    // Loopback sweep 128 -> 1 -> 255
    set_now(128, 256);
    do_reset(1'b0);
    wait_vals(4, 1500, "sw128_seen");
    check("sw128_first", vq[0], 128);
    check("sw128_first_lat", int'(tq[0] - rel <= 520), 1);
    check("sw128_last", vq[3], 128);
    check("sw128_rate", tq[3] - tq[2], 256);
    check("sw128_err", perr_n, 0);
    foreach (sw[i]) begin
      n_hi = sw[i];
      clr();
      wait_vals(4, 1500, "sw_seen");
      check("sw_duty_a", vq[2], sw[i]);
      check("sw_duty_b", vq[3], sw[i]);
      check("sw_rate", tq[3] - tq[2], 256);
      check("sw_err", perr_n, 0);
    end

    // Stuck high, then release to duty 64
    set_now(256, 256);
    do_reset(1'b0);
    wait_clk(600);
    check("sh_count", vq.size(), 1);
    check("sh_duty", vq[0], 255);
    check("sh_level", stat, 1);
    set_now(64, 256);
    clr();
    wait_clk(30);
    check("sh_hold", stat, 1);
    wait_clk(50);
    check("sh_drop", stat, 0);
    wait_vals(1, 700, "sh_rel_seen");
    check("sh_rel_duty", vq[0], 64);
    check("sh_rel_err", perr_n, 0);

    // Bad period: 100 high / 200 low
    n_hi  = 100;
    n_len = 300;
    wait_clk(300);
    clr();
    wait_clk(1000);
    check("bp_valid", vq.size(), 0);
    check("bp_errs", int'(perr_n >= 2), 1);
    check("bp_duty", duty, 64);

    // Mid-pulse reset at duty 200
    set_now(200, 256);
    wait_clk(600);
    check("mr_pre", duty, 200);
    k = 0;
    while (g_ctr != 50 && k < 400) begin
      wait_clk(1);
      k++;
    end
    check("mr_phase", int'(pwm), 1);
    rst = 1'b1;
    #1;
    check("mr_duty", duty, 0);
    check("mr_valid", vld, 0);
    check("mr_static", stat, 0);
    wait_clk(2);
    rst = 1'b0;
    rel = cyc;
    clr();
    wait_vals(1, 700, "mr_seen");
    check("mr_post", vq[0], 200);
    check("mr_lat", int'(tq[0] - rel <= 520), 1);
    check("mr_err", perr_n, 0);

    // Duty change 50 -> 180 at a period boundary
    set_now(50, 256);
    do_reset(1'b0);
    wait_vals(2, 1500, "dc_pre_seen");
    check("dc_pre", vq[1], 50);
    n_hi = 180;
    clr();
    wait_vals(3, 1000, "dc_seen");
    check("dc_old", vq[0], 50);
    check("dc_new_a", vq[1], 180);
    check("dc_new_b", vq[2], 180);
    check("dc_err", perr_n, 0);

    check("excl", both_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
